// File: rtl/ysyx_23060332_lsu_ctrl.sv
// ysyx_23060332_lsu_ctrl
//  Multi-cycle load/store sequencer sitting between the EXU memory intent
//  and a valid/ready data-memory bus. One bus request is issued per accepted
//  load/store. The pipeline is stalled until the response returns, and the
//  captured load data is handed back to the EXU for extension.
//
//  Optional feature macro: LSU_TIMEOUT_EN
//   When defined, an abort counter ends an access that hangs in REQ/WAIT.
//   The abort completes with o_err=1 and o_ld_rdata=0.
//   When undefined, o_err is tied 0 and REQ/WAIT wait indefinitely.
//
//  Ports
//   clk, rst_n                      clock (rising), async active-low reset
//   i_ex_valid/ren/wen/addr/wdata   EXU memory intent
//   i_ex_wmask                      EXU byte mask
//   o_stall                         hold IF/ID/EX while the access is in flight
//   o_done                          1-cycle completion pulse
//   o_ld_rdata                      captured load data
//   o_err                           timeout abort flag, pulses with o_done
//   o_req_*, i_req_ready            request channel
//   i_rsp_valid, o_rsp_ready        response channel
//   i_rsp_rdata                     read data on the response channel
//
//  state  | meaning
//  S_IDLE | waiting for an EXU load/store; latches it on accept
//  S_REQ  | request presented on the bus until i_req_ready
//  S_WAIT | request taken, waiting for the response
//  S_DONE | one-cycle completion; pipeline advances
module ysyx_23060332_lsu_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ex_valid,
   input  logic              i_ex_ren,
   input  logic              i_ex_wen,
   input  logic [ADDR_W-1:0] i_ex_addr,
   input  logic [DATA_W-1:0] i_ex_wdata,
   input  logic [7:0]        i_ex_wmask,
   output logic              o_stall,
   output logic              o_done,
   output logic [DATA_W-1:0] o_ld_rdata,
   output logic              o_err,
   output logic              o_req_valid,
   input  logic              i_req_ready,
   output logic              o_req_wen,
   output logic [ADDR_W-1:0] o_req_addr,
   output logic [DATA_W-1:0] o_req_wdata,
   output logic [7:0]        o_req_wmask,
   input  logic              i_rsp_valid,
   output logic              o_rsp_ready,
   input  logic [DATA_W-1:0] i_rsp_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic              w_timeout;
   logic              w_abort;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_wmask;
   logic [DATA_W-1:0] r_rdata;

`ifdef LSU_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       r_err;

   // The counter holds (cycles spent in REQ/WAIT) - 1. Aborting when it reads
   // TIMEOUT_CYCLES-2 places the DONE cycle exactly TIMEOUT_CYCLES cycles
   // after the accept cycle.
   assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 2));
   assign o_err     = (r_state == S_DONE) & r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (r_state == S_REQ || r_state == S_WAIT) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_abort) r_err <= 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign o_err     = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_abort     = 1'b0;
      o_stall     = 1'b0;
      o_req_valid = 1'b0;
      o_rsp_ready = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = i_ex_valid & (i_ex_ren | i_ex_wen);
            o_stall  = w_accept;
            if (w_accept) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            o_stall = 1'b1;
            // Withdraw the request in the abort cycle so no late handshake
            // can sneak through.
            o_req_valid = ~w_timeout;
            if (w_timeout) begin
               w_abort     = 1'b1;
               w_state_nxt = S_DONE;
            end else if (i_req_ready) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            o_stall     = 1'b1;
            o_rsp_ready = 1'b1;
            // A response arriving in the abort cycle still wins.
            if (i_rsp_valid) begin
               w_state_nxt = S_DONE;
            end else if (w_timeout) begin
               w_abort     = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            // Load+store together is issued as a store.
            r_wen   <= i_ex_wen;
            r_addr  <= i_ex_addr;
            r_wdata <= i_ex_wen ? i_ex_wdata : '0;
            r_wmask <= i_ex_wen ? i_ex_wmask : 8'h00;
         end
         if (r_state == S_WAIT && i_rsp_valid && !r_wen) r_rdata <= i_rsp_rdata;
         else if (w_abort)                                r_rdata <= '0;
      end
   end

   assign o_req_wen   = r_wen;
   assign o_req_addr  = r_addr;
   assign o_req_wdata = r_wdata;
   assign o_req_wmask = r_wmask;
   assign o_ld_rdata  = r_rdata;

endmodule

// File: tb/tb_ysyx_23060332_lsu_ctrl.sv
module tb_ysyx_23060332_lsu_ctrl;

   localparam int TO = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ren, ex_wen;
   logic [31:0] ex_addr, ex_wdata;
   logic [7:0]  ex_wmask;
   logic        stall, done, err;
   logic [31:0] ld_rdata;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [7:0]  req_wmask;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_23060332_lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_ex_valid(ex_valid), .i_ex_ren(ex_ren), .i_ex_wen(ex_wen),
      .i_ex_addr(ex_addr), .i_ex_wdata(ex_wdata), .i_ex_wmask(ex_wmask),
      .o_stall(stall), .o_done(done), .o_ld_rdata(ld_rdata), .o_err(err),
      .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_wen(req_wen),
      .o_req_addr(req_addr), .o_req_wdata(req_wdata), .o_req_wmask(req_wmask),
      .i_rsp_valid(rsp_valid), .o_rsp_ready(rsp_ready), .i_rsp_rdata(rsp_rdata)
   );

   typedef struct {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  mask;
      int          rd;      // cycles req_ready is held low in REQ
      int          sd;      // cycles rsp_valid is held low in WAIT
      logic [31:0] rdata;
      logic        exp_wen;
      logic [31:0] exp_wdata;
      logic [7:0]  exp_wmask;
      logic [31:0] exp_ld;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Caller sits between edges with the DUT idle.
   task automatic run_txn(input vec_t v, input int id);
      int dc;
      int hs;
      dc = 3 + v.rd + v.sd;
      hs = 0;
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_ren = v.ren; ex_wen = v.wen;
      ex_addr = v.addr; ex_wdata = v.wdata; ex_wmask = v.mask;
      @(negedge clk);
      chk($sformatf("v%0d accept stall", id), stall, 1);
      chk($sformatf("v%0d accept req_valid", id), req_valid, 0);
      for (int c = 1; c <= dc; c++) begin
         @(posedge clk); #1;
         req_ready = (c == 1 + v.rd);
         rsp_valid = (c == 2 + v.rd + v.sd);
         rsp_rdata = v.rdata;
         @(negedge clk);
         if (req_valid && req_ready) hs++;
         chk($sformatf("v%0d c%0d req_valid", id, c), req_valid, (c <= 1 + v.rd));
         chk($sformatf("v%0d c%0d rsp_ready", id, c), rsp_ready,
             (c >= 2 + v.rd && c <= 2 + v.rd + v.sd));
         chk($sformatf("v%0d c%0d done", id, c), done, (c == dc));
         chk($sformatf("v%0d c%0d stall", id, c), stall, (c < dc));
         if (c <= 1 + v.rd) begin
            chk($sformatf("v%0d c%0d req_wen", id, c), req_wen, v.exp_wen);
            chk($sformatf("v%0d c%0d req_addr", id, c), req_addr, v.addr);
            chk($sformatf("v%0d c%0d req_wdata", id, c), req_wdata, v.exp_wdata);
            chk($sformatf("v%0d c%0d req_wmask", id, c), req_wmask, v.exp_wmask);
         end
      end
      chk($sformatf("v%0d ld_rdata", id), ld_rdata, v.exp_ld);
      chk($sformatf("v%0d err", id), err, 0);
      chk($sformatf("v%0d handshakes", id), hs, 1);
      ex_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
   endtask

   initial begin
      vec_t lb;
      //          ren wen addr          wdata         mask  rd sd rdata         ewen ewdata        emask  eld
      vecs[0] = '{1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, 32'h1234_5678, 1'b0, 32'h0,         8'h00, 32'h1234_5678};
      vecs[1] = '{1'b0, 1'b1, 32'h8000_0004, 32'hA5A5_A5A5, 8'h0F, 4, 0, 32'hFFFF_0000, 1'b1, 32'hA5A5_A5A5, 8'h0F, 32'h1234_5678};
      vecs[2] = '{1'b1, 1'b1, 32'h8000_0020, 32'h0000_00C3, 8'h01, 1, 2, 32'hBAD0_BAD0, 1'b1, 32'h0000_00C3, 8'h01, 32'h1234_5678};
      vecs[3] = '{1'b1, 1'b0, 32'h8000_0003, 32'h0000_0012, 8'h01, 2, 3, 32'h0000_0080, 1'b0, 32'h0,         8'h00, 32'h0000_0080};
      vecs[4] = '{1'b1, 1'b0, 32'h8000_0102, 32'h0,         8'h03, 0, 1, 32'hCAFE_F00D, 1'b0, 32'h0,         8'h00, 32'hCAFE_F00D};
      vecs[5] = '{1'b0, 1'b1, 32'h8000_0200, 32'h0000_BEEF, 8'h03, 0, 0, 32'h1111_1111, 1'b1, 32'h0000_BEEF, 8'h03, 32'hCAFE_F00D};

      rst_n = 1'b0;
      ex_valid = 1'b0; ex_ren = 1'b0; ex_wen = 1'b0;
      ex_addr = '0; ex_wdata = '0; ex_wmask = '0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;

      #12;
      chk("reset stall", stall, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset req_valid", req_valid, 0);
      chk("reset rsp_ready", rsp_ready, 0);
      chk("reset ld_rdata", ld_rdata, 0);
      chk("reset req_addr", req_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

      // Stray response while idle must be ignored.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         rsp_valid = 1'b1; rsp_rdata = 32'h5555_AAAA;
         @(negedge clk);
         chk($sformatf("stray c%0d done", c), done, 0);
         chk($sformatf("stray c%0d req_valid", c), req_valid, 0);
         chk($sformatf("stray c%0d rsp_ready", c), rsp_ready, 0);
         chk($sformatf("stray c%0d ld_rdata", c), ld_rdata, 32'hCAFE_F00D);
      end
      rsp_valid = 1'b0;

      // Reset while waiting for a response.
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = 32'h8000_0040; ex_wmask = 8'h0F;
      @(posedge clk); #1;
      req_ready = 1'b1;
      @(posedge clk); #1;
      req_ready = 1'b0; ex_valid = 1'b0;
      @(negedge clk);
      chk("rstwait pre rsp_ready", rsp_ready, 1);
      chk("rstwait pre stall", stall, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstwait req_valid", req_valid, 0);
      chk("rstwait rsp_ready", rsp_ready, 0);
      chk("rstwait stall", stall, 0);
      chk("rstwait done", done, 0);
      chk("rstwait ld_rdata", ld_rdata, 0);
      chk("rstwait req_addr", req_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      lb = '{1'b1, 1'b0, 32'h8000_0041, 32'h0, 8'h01, 0, 0, 32'h0000_007F, 1'b0, 32'h0, 8'h00, 32'h0000_007F};
      run_txn(lb, 6);

`ifdef LSU_TIMEOUT_EN
      // Bus never takes the request: abort at TO cycles after accept.
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = 32'h8000_0080; ex_wmask = 8'h0F;
      for (int c = 1; c <= TO; c++) begin
         @(posedge clk); #1;
         req_ready = 1'b0;
         @(negedge clk);
         if (done || c == TO) begin
            chk($sformatf("timeout c%0d done", c), done, (c == TO));
            chk($sformatf("timeout c%0d err", c), err, (c == TO));
         end
         if (c == TO) chk("timeout ld_rdata", ld_rdata, 0);
      end
      ex_valid = 1'b0;
      @(posedge clk); #1;
      rsp_valid = 1'b1; rsp_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("timeout stray done", done, 0);
      chk("timeout stray err", err, 0);
      chk("timeout stray ld_rdata", ld_rdata, 0);
      rsp_valid = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
